// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: state encodings and default operand width.
package mul_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_ctrl.sv
// Control path of the shift-add multiplier: IDLE/CALC/DONE sequencer plus step counter.
// Status outputs are registered from the next-state decode so they line up with the state register.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic early_last,
    output logic ready,
    output logic busy,
    output logic done,
    output logic accept,
    output logic last_step
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    mul_state_t    state_r;
    mul_state_t    state_nx_s;
    logic [CW-1:0] cnt_r;
    logic          ready_r;
    logic          busy_r;
    logic          done_r;

    assign accept    = start & ready_r;
    assign last_step = busy_r & ((cnt_r == CW'(W - 1)) | early_last);
    assign ready     = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register, registered status flags and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == ST_IDLE);
            busy_r  <= (state_nx_s == ST_CALC);
            done_r  <= (state_nx_s == ST_DONE);
            if (accept) begin
                cnt_r <= {CW{1'b0}};
            end else if (busy_r) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one add/shift step per clock, feeding the BCD converter.
// Optional macro MUL_EARLY_TERM_EN ends the run once no multiplier bits remain set.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [2*W-1:0] mcand_r;
    logic [2*W-1:0] acc_r;
    logic [2*W-1:0] acc_nx_s;
    logic [2*W-1:0] product_r;
    logic [W-1:0]   mplier_r;
    logic           accept_s;
    logic           last_step_s;
    logic           early_s;

`ifdef MUL_EARLY_TERM_EN
    assign early_s = ((mplier_r >> 1) == {W{1'b0}});
`else
    assign early_s = 1'b0;
`endif

    mul_ctrl #(.W(W)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .early_last (early_s),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .accept     (accept_s),
        .last_step  (last_step_s)
    );

    // Accumulator value after the current step; the final step's value goes straight to product
    always_comb begin
        acc_nx_s = acc_r;
        if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
        end else begin
            acc_nx_s = acc_r;
        end
    end

    // Datapath registers: load on accept, shift/accumulate while calculating
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
        end else if (accept_s) begin
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= {(2*W){1'b0}};
        end else if (busy) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_nx_s;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

    // Product register changes only on the transition into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            product_r <= {(2*W){1'b0}};
        end else if (last_step_s) begin
            product_r <= acc_nx_s;
        end else begin
            product_r <= product_r;
        end
    end

    assign product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus random operands
// against a plain-arithmetic reference (product = a*b, latency from the multiplier's bit length).
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_assert;
    int n_fail;

    shift_add_multiplier #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference latency in steps, derived from the multiplier's value
    function automatic int ref_lat(input int bv);
        int msb;
`ifdef MUL_EARLY_TERM_EN
        msb = -1;
        for (int i = 0; i < W; i++) begin
            if (((bv >> i) & 1) == 1) msb = i;
        end
        return (msb < 1) ? 1 : msb + 1;
`else
        msb = bv;
        return W;
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_timeout", 32'(n < 20), 32'd1);
    endtask

    // Full transaction: accept, count cycles to done, check result and handshake
    task automatic run_mul(input int av, input int bv, input string tag);
        int n;
        logic [2*W-1:0] prev;
        wait_ready();
        prev  = product;
        a     = W'(av);
        b     = W'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 3 * W) begin
            if (product !== prev) chk({tag, "_hold"}, 32'(product), 32'(prev));
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(ref_lat(bv)));
        chk({tag, "_prod"}, 32'(product), 32'(av * bv));
        chk({tag, "_rdy_in_done"}, 32'({ready, busy}), 32'd0);
        @(negedge clk);
        chk({tag, "_rdy_after"}, 32'({ready, busy, done}), 32'b100);
        chk({tag, "_prod_held"}, 32'(product), 32'(av * bv));
    endtask

    initial begin
        int n;
        int gap;
        n_assert = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", 32'({ready, busy, done}), 32'b100);
        chk("reset_prod", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_mul(15, 15, "t1_15x15");
        run_mul(7, 0, "t2_7x0");

        // Start during CALC must be ignored
        wait_ready();
        a = 4'd9; b = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd3; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        chk("t3_ignored_prod", 32'(product), 32'd54);
        @(negedge clk);
        repeat (W + 2) begin
            chk("t3_no_requeue", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Reset during the second CALC cycle aborts with no done pulse
        wait_ready();
        a = 4'd12; b = 4'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_abort_flags", 32'({ready, busy, done}), 32'b100);
        chk("t4_abort_prod", 32'(product), 32'd0);
        repeat (W + 2) begin
            @(negedge clk);
            chk("t4_no_done", 32'({done, busy}), 32'd0);
        end

        // Start held high: back-to-back accepts, done spacing = latency + 2
        wait_ready();
        a = 4'd5; b = 4'd5; start = 1'b1;
        @(negedge clk);
        a = 4'd15; b = 4'd1;
        n = 0;
        while (done !== 1'b1 && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        chk("t5_prod1", 32'(product), 32'd25);
        gap = 0;
        @(negedge clk);
        gap++;
        while (done !== 1'b1 && gap < 4 * W) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        chk("t5_prod2", 32'(product), 32'd15);
        chk("t5_gap", 32'(gap), 32'(ref_lat(1) + 2));
        @(negedge clk);

        run_mul(10, 1, "t6_10x1");
        run_mul(10, 8, "t6_10x8");

        for (int i = 0; i < 20; i++) begin
            run_mul(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
